// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants for the prefetching fetch stage: word
//               increment, FSM state encoding and next-PC target selection.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Byte distance between consecutive instruction words
    localparam int unsigned C_WORD_INC = 4;

    // Fetch FSM states
    localparam logic [0:0] C_ST_RUN     = 1'b0;
    localparam logic [0:0] C_ST_DISCARD = 1'b1;

    // Next-PC target selection
    localparam logic [1:0] C_SEL_SEQ = 2'd0;
    localparam logic [1:0] C_SEL_BR  = 2'd1;
    localparam logic [1:0] C_SEL_JMP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of DEPTH x WIDTH holding fetched
//               {pc, instruction} pairs. Flush wins over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Pop on empty is ignored; a push into a full queue is only taken when a pop frees a slot
    always_comb begin
        w_do_pop  = pop & ~empty;
        w_do_push = push & (~full | w_do_pop);
    end

    // Pointer and occupancy tracking; flush empties the queue on the same edge
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch
// Description : Fetch stage with PC/next-PC logic, req/ack instruction memory
//               handshake, DEPTH-entry prefetch queue and valid/ready decode
//               interface. Redirects flush the queue and squash in-flight data.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     OFF_W    = 16,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_instr,
    output logic [XLEN-1:0]   id_pc,
    input  logic              br,
    input  logic              z,
    input  logic [XLEN-1:0]   br_pc,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              jmp,
    input  logic [XLEN-1:0]   jmp_addr,
    output logic              busy
);

    localparam int unsigned     CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0] C_INC        = XLEN'(C_WORD_INC);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [XLEN-1:0]   r_fetch_pc;
    logic              r_req;
    logic [XLEN-1:0]   r_addr;

    logic              w_ack;
    logic              w_hold;
    logic              w_taken;
    logic              w_redirect;
    logic [1:0]        w_sel;
    logic [XLEN-1:0]   w_off_ext;
    logic [XLEN-1:0]   w_seq_pc;
    logic [XLEN-1:0]   w_br_target;
    logic [XLEN-1:0]   w_jmp_target;
    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_pc_next;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [CNT_W-1:0]  w_cnt_after;

    logic [2*XLEN-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    // An ack only means something while a request is actually outstanding
    assign w_ack      = imem_ack & r_req;
    assign w_hold     = r_req & ~imem_ack;
    assign w_taken    = br & z;
    assign w_redirect = jmp | w_taken;

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign id_valid   = ~w_empty;
    assign id_pc      = w_head[2*XLEN-1:XLEN];
    assign id_instr   = w_head[XLEN-1:0];
    assign w_pop      = id_valid & id_ready;

    // Candidate targets; all sums wrap modulo 2^XLEN
    always_comb begin
        w_off_ext    = {{(XLEN-OFF_W){br_off[OFF_W-1]}}, br_off};
        w_seq_pc     = r_fetch_pc + C_INC;
        w_br_target  = br_pc + C_INC + (w_off_ext << 2);
        w_jmp_target = jmp_addr & C_ALIGN_MASK;
    end

    // Next-PC selection: jump beats a taken branch, otherwise advance on an accepted fetch
    always_comb begin
        w_sel = C_SEL_SEQ;
        if (jmp) begin
            w_sel = C_SEL_JMP;
        end else if (w_taken) begin
            w_sel = C_SEL_BR;
        end
        case (w_sel)
            C_SEL_JMP: w_target = w_jmp_target;
            C_SEL_BR:  w_target = w_br_target;
            default:   w_target = w_seq_pc;
        endcase
        w_pc_next = r_fetch_pc;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (w_push) begin
            w_pc_next = w_seq_pc;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a redirect with an unfinished request must wait out its ack
    always_comb begin
        w_state_next = r_state;
        if (w_redirect) begin
            w_state_next = w_hold ? C_ST_DISCARD : C_ST_RUN;
        end else if ((r_state == C_ST_DISCARD) && w_ack) begin
            w_state_next = C_ST_RUN;
        end
    end

    // FSM outputs: push accepted data, decide whether a new request starts next cycle
    always_comb begin
        w_push      = w_ack & (r_state == C_ST_RUN) & ~w_redirect & (~w_full | w_pop);
        w_cnt_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_issue     = ~w_hold & ~w_redirect & (w_state_next == C_ST_RUN) &
                      (w_cnt_after < C_DEPTH);
        busy        = w_hold | (r_state == C_ST_DISCARD);
    end

    // Fetch PC and request registers; address is only reloaded when a new request starts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
        end else begin
            r_fetch_pc <= w_pc_next;
            r_req      <= w_hold | w_issue;
            if (w_issue) begin
                r_addr <= w_pc_next;
            end
        end
    end

    fetch_queue #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({r_addr, imem_rdata}),
        .pop       (w_pop),
        .flush     (w_redirect),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised successor to the single-cycle PC/branch fetch stage.
- Holds the fetch PC and computes next-PC as sequential, conditional PC-relative branch, or absolute jump.
- Talks to instruction memory over a request/acknowledge handshake and buffers fetched instructions in a DEPTH-entry prefetch queue.
- Decode consumes instructions through a valid/ready interface; redirects flush the queue and squash any in-flight fetch.

Parameters:
XLEN, 32, address and instruction width
DEPTH, 4, prefetch queue entries (power of two, at least 2)
OFF_W, 16, branch offset width (signed word offset)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, word aligned
imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req
imem_rdata  in  XLEN  instruction word, valid when imem_ack=1
id_valid  out  1  queue head valid
id_ready  in  1  decode accepts the head
id_instr  out  XLEN  head instruction
id_pc  out  XLEN  head instruction address
br  in  1  conditional branch resolved this cycle
z  in  1  condition flag; branch taken = br & z
br_pc  in  XLEN  address of the branching instruction
br_off  in  OFF_W  signed word offset
jmp  in  1  absolute jump this cycle
jmp_addr  in  XLEN  jump target
busy  out  1  fetch request outstanding or discard pending

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc = RESET_PC; queue empty.
  - imem_req=0, id_valid=0, busy=0, state=RUN.
  - rst has priority over every other input.
- Targets (all arithmetic modulo 2^XLEN, wrap silent):
  - Sequential: fetch_pc + 4.
  - Branch: br_pc + 4 + (sign_extend(br_off) << 2).
  - Jump: jmp_addr with bits [1:0] forced to 0.
- Redirect = jmp | (br & z); jmp has priority over a branch in the same cycle.
- Memory handshake:
  - Once raised, imem_req stays high with imem_addr stable until the imem_ack cycle.
  - At most one request outstanding.
  - A new request may start the cycle after an ack.
  - Issue condition: state=RUN, no redirect this cycle, and (queue count + outstanding) < DEPTH.
  - Minimum latency is 1 cycle from reset release to imem_req=1.
- On an ack in RUN:
  - Push {fetch_pc, imem_rdata} to the queue.
  - fetch_pc = fetch_pc + 4.
- States:
  - RUN: normal operation.
  - DISCARD: a redirect occurred while a request was outstanding without ack that cycle. Hold imem_req/imem_addr per the handshake. On ack, drop rdata, go to RUN, and issue from the new PC the next cycle.
- Redirect in any state:
  - Queue cleared and fetch_pc = target on the same edge.
  - An ack in the redirect cycle is discarded and the state stays RUN.
  - A redirect during DISCARD updates fetch_pc and stays in DISCARD.
- Decode interface:
  - id_valid = queue non-empty and no redirect in this cycle's registered state (queue outputs are registered).
  - Pop when id_valid & id_ready.
  - Pop and redirect in the same cycle: the pop completes, then the flush empties the queue.
- Boundaries:
  - Push and pop in the same cycle with the queue full is legal; count is unchanged.
  - Pop on empty is ignored.
  - busy = (imem_req & ~imem_ack) | (state==DISCARD).

Decomposition:
- Package fetch_pkg holds:
  - the word increment constant (4);
  - the state encoding (RUN, DISCARD);
  - the target-select encoding (SEQ, BR, JMP).
- Sub-module fetch_queue: synchronous FIFO of DEPTH x (2*XLEN) with push, pop, flush, count, full and empty; flush has priority over push.
- Next-PC adders and the FSM stay in the top module.

Test Plan:
- Reset release with RESET_PC=0 and zero-wait ack (ack tied to req), id_ready=1 → imem_addr sequence 0,4,8,C; id_pc follows 0,4,8 with instr equal to the memory contents.
- id_ready=0 with DEPTH=4 → exactly 4 pushes, then imem_req stays 0. Raise id_ready for 1 cycle → one pop, one new request at addr 0x10.
- br=1, z=1, br_pc=0x08, br_off=-3 with the queue holding 0x0C,0x10 → queue flushed; next imem_addr = 0x08+4-12 = 0x00.
- Same branch with z=0 → no flush; fetch continues sequentially.
- Memory ack delayed 3 cycles, jmp=1 with jmp_addr=0x103 one cycle after the request at 0x20 → state DISCARD and busy=1; the ack data for 0x20 is never presented on id_*; next request at 0x100.
- fetch_pc=0xFFFFFFFC with ack → next imem_addr 0x00000000 (wrap). Assert rst mid-DISCARD → all outputs at reset values on the next edge; first request at RESET_PC.
